// File: rtl/chess_pkg.sv
// Shared types for the chess clock timing core: FSM states, per-player time
// record, and the countdown/clamp helpers used by the top.
package chess_pkg;

    localparam int TW      = 6;
    localparam int SEC_MAX = 59;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_P1 = 3'd1,
        RUN_P2 = 3'd2,
        PAUSED = 3'd3,
        FLAG   = 3'd4
    } state_t;

    typedef struct packed {
        logic [TW-1:0] mins;
        logic [TW-1:0] secs;
    } ptime_t;

    // One-second decrement with borrow; 00:00 is a fixed point so it can never wrap.
    function automatic ptime_t time_dec(input ptime_t t);
        ptime_t r;
        r = t;
        if (t.secs != '0) begin
            r.secs = t.secs - TW'(1);
        end else if (t.mins != '0) begin
            r.mins = t.mins - TW'(1);
            r.secs = TW'(SEC_MAX);
        end
        return r;
    endfunction

    function automatic logic time_zero(input ptime_t t);
        return (t.mins == '0) && (t.secs == '0);
    endfunction

    // A zero-minute game is meaningless, so 0 loads as 1 minute.
    function automatic logic [TW-1:0] clamp_min(input logic [TW-1:0] m,
                                                input logic [TW-1:0] maxv);
        logic [TW-1:0] r;
        if (m == '0)
            r = TW'(1);
        else if (m > maxv)
            r = maxv;
        else
            r = m;
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Purpose: one-second prescaler producing a single-cycle tick on wrap.
// Latency: first tick TICK_DIV cycles after clr drops with en high; tick is combinational from the count.
// Backpressure: none; clr overrides en, en low freezes the count.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Tick stays visible while clr is asserted so a switch on a tick edge still decrements.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/chess_countdown.sv
// Purpose: chess clock timing core; holds both players' mm:ss and counts the active one down.
// Latency: inputs registered once, edges act one cycle later; first decrement TICK_DIV cycles after start/switch/resume.
// Backpressure: none; simultaneous btn1+btn2 edges are dropped and start takes priority over buttons.
module chess_countdown
    import chess_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int CFG_MAX  = 59
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] cfg_min,
    input  logic          start,
    input  logic          btn1,
    input  logic          btn2,
    output logic [TW-1:0] min1,
    output logic [TW-1:0] seg1,
    output logic [TW-1:0] min2,
    output logic [TW-1:0] seg2,
    output logic          turn,
    output logic          running,
    output logic          flag1,
    output logic          flag2
);

    state_t        state;
    logic          start_q, start_p;
    logic          btn1_q, btn1_p;
    logic          btn2_q, btn2_p;
    logic [TW-1:0] cfg_q;
    logic          start_e, btn1_e, btn2_e;
    logic          sw1, sw2;
    logic          pre_clr, pre_en, tick;
    logic [TW-1:0] load_min;
    ptime_t        p1_dec, p2_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            start_p <= 1'b0;
            btn1_q  <= 1'b0;
            btn1_p  <= 1'b0;
            btn2_q  <= 1'b0;
            btn2_p  <= 1'b0;
            cfg_q   <= '0;
        end else begin
            start_q <= start;
            start_p <= start_q;
            btn1_q  <= btn1;
            btn1_p  <= btn1_q;
            btn2_q  <= btn2;
            btn2_p  <= btn2_q;
            cfg_q   <= cfg_min;
        end
    end

    assign start_e = start_q & ~start_p;
    assign btn1_e  = btn1_q & ~btn1_p;
    assign btn2_e  = btn2_q & ~btn2_p;

    // Move-end requests: both buttons together cancel out, and start outranks either.
    assign sw1 = btn1_e & ~btn2_e & ~start_e;
    assign sw2 = btn2_e & ~btn1_e & ~start_e;

    assign load_min = clamp_min(cfg_q, TW'(CFG_MAX));
    assign p1_dec   = time_dec({min1, seg1});
    assign p2_dec   = time_dec({min2, seg2});

    assign pre_en = (state == RUN_P1) || (state == RUN_P2);

    always_comb begin
        pre_clr = 1'b1;
        case (state)
            RUN_P1:  pre_clr = sw1;
            RUN_P2:  pre_clr = sw2;
            PAUSED:  pre_clr = start_e;
            default: pre_clr = 1'b1;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            min1    <= '0;
            seg1    <= '0;
            min2    <= '0;
            seg2    <= '0;
            turn    <= 1'b0;
            running <= 1'b0;
            flag1   <= 1'b0;
            flag2   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    min1    <= load_min;
                    seg1    <= '0;
                    min2    <= load_min;
                    seg2    <= '0;
                    turn    <= 1'b0;
                    running <= 1'b0;
                    flag1   <= 1'b0;
                    flag2   <= 1'b0;
                    if (start_e) begin
                        state   <= RUN_P1;
                        running <= 1'b1;
                    end
                end
                RUN_P1: begin
                    if (start_e) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else begin
                        if (tick) begin
                            min1 <= p1_dec.mins;
                            seg1 <= p1_dec.secs;
                        end
                        // Running out of time beats a move made on the same tick.
                        if (tick && time_zero(p1_dec)) begin
                            state   <= FLAG;
                            flag1   <= 1'b1;
                            running <= 1'b0;
                        end else if (sw1) begin
                            state <= RUN_P2;
                            turn  <= 1'b1;
                        end
                    end
                end
                RUN_P2: begin
                    if (start_e) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else begin
                        if (tick) begin
                            min2 <= p2_dec.mins;
                            seg2 <= p2_dec.secs;
                        end
                        if (tick && time_zero(p2_dec)) begin
                            state   <= FLAG;
                            flag2   <= 1'b1;
                            running <= 1'b0;
                        end else if (sw2) begin
                            state <= RUN_P1;
                            turn  <= 1'b0;
                        end
                    end
                end
                PAUSED: begin
                    if (start_e) begin
                        state   <= turn ? RUN_P2 : RUN_P1;
                        running <= 1'b1;
                    end
                end
                FLAG: begin
                    if (start_e) begin
                        state <= IDLE;
                        flag1 <= 1'b0;
                        flag2 <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
